uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal 5..8).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, reset; asynchronous and active-high.
REQ-005 The block SHALL have port baud_tick, input, 1, a one-clk-wide bit-period strobe from the baud clock divider.
REQ-006 The block SHALL have port tx_data, input, 8, the byte to send; only bits [DATA_BITS-1:0] are used.
REQ-007 The block SHALL have port tx_valid, input, 1, which requests transmission of tx_data.
REQ-008 The block SHALL have port tx_ready, output, 1, high only in IDLE; acceptance = tx_valid & tx_ready.
REQ-009 The block SHALL have port tx, output, 1, the registered serial line; it idles high.
REQ-010 The block SHALL have port tx_busy, output, 1, high whenever state != IDLE.
REQ-011 The block SHALL have port tx_done, output, 1, a one-clk pulse at frame completion.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, START, DATA, PARITY (present only with the macro), and STOP.
REQ-013 On acceptance the block SHALL latch tx_data into a shift register and go IDLE->LOAD, ignoring any baud_tick in that same cycle.
REQ-014 tx and all state transitions out of LOAD SHALL change only in cycles where baud_tick=1.
REQ-015 On the first tick in LOAD the block SHALL set tx<=0 and go to START.
REQ-016 On the next tick the block SHALL drive data bit 0, go to DATA, and set bit index=0.
REQ-017 On each tick in DATA the block SHALL drive the next bit, LSB first, for DATA_BITS bits total.
REQ-018 After the last data bit, the next tick SHALL drive the parity bit (PARITY) when the macro is enabled, otherwise drive tx<=1 and enter STOP.
REQ-019 STOP SHALL hold tx=1 for STOP_BITS tick periods; the tick ending the last stop bit SHALL return the FSM to IDLE and pulse tx_done in that cycle.
REQ-020 Frame length from acceptance SHALL be 2+DATA_BITS+STOP_BITS ticks, plus 1 with parity; for default parameters without parity, tx_done is asserted on the 11th tick.
REQ-021 tx_ready SHALL rise in the cycle after tx_done; back-to-back frames SHALL re-accept from that cycle.
REQ-022 tx_valid and tx_data changes while busy SHALL be ignored, and the latched byte SHALL be unaffected.
REQ-023 A baud_tick lasting more than one cycle SHALL advance the FSM once per high cycle; the source guarantees single-cycle ticks.
REQ-024 The bit index SHALL be a 3-bit counter that does not wrap within a frame and is cleared on entry to DATA.

Reset
REQ-025 While reset=1 the block SHALL force, asynchronously, state=IDLE, tx=1, tx_busy=0, tx_done=0, and clear the shift register and bit index.
REQ-026 tx_ready SHALL be 1 during reset and in the first cycle after release.
REQ-027 Reset asserted mid-frame SHALL abort the frame with tx high immediately and no tx_done.

Configuration
REQ-028 Macro UART_TX_PARITY_EN SHALL, when defined, include the PARITY state and add parameter PARITY_ODD (default 0).
REQ-029 With UART_TX_PARITY_EN defined, the parity bit SHALL be the XOR of the data bits, XOR PARITY_ODD.
REQ-030 Without UART_TX_PARITY_EN, the PARITY state and PARITY_ODD SHALL be absent and frames SHALL be start+data+stop only.

Verification
REQ-031 Scenario: reset pulse then 20 clk idle -> tx=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
REQ-032 Scenario: send 0xA5 with ticks every 16 clk, no parity -> tx per tick 0,1,0,1,0,0,1,0,1,1, with tx_done on the 11th tick.
REQ-033 Scenario: UART_TX_PARITY_EN with 0xA5 -> parity bit 0 when PARITY_ODD=0 and 1 when PARITY_ODD=1, with tx_done on the 12th tick.
REQ-034 Scenario: tx_valid asserted in the same cycle as baud_tick -> start bit appears on the following tick, not the coincident one.
REQ-035 Scenario: 0x3C then 0xC3 held valid back-to-back -> second start bit on the first tick after tx_ready rises, with no extra idle bit and both bytes correct.
REQ-036 Scenario: reset asserted during DATA bit 4 -> tx=1 within the same cycle, and no tx_done until a new frame completes.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS payload (LSB first), optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to add the PARITY state and the PARITY_ODD parameter.
module uart_tx #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // data_q shifts right as bits go out, so data_q[0] is always the next payload bit
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        tx_done    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    data_d  = tx_data[DATA_BITS-1:0];
                    state_d = LOAD;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^tx_data[DATA_BITS-1:0]) ^ PARITY_ODD;
`endif
                end
            end
            LOAD: begin
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_d      = data_q[0];
                    data_d    = data_q >> 1;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
`endif
                    end else begin
                        tx_d      = data_q[0];
                        data_d    = data_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        tx_done = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = (state_q == IDLE);
    assign tx_busy  = (state_q != IDLE);

endmodule
